cpu_bus_router: RTL
===================

Name: cpu_bus_router

Overview:
Parametrised successor to the single-target CPU register decode in the Flipper top level. It takes one upstream CPU register access (read/write strobe, 16-bit address, 32-bit data) and routes it to one of NUM_SLAVES sub-blocks (CP, PE, VI, ...) selected by the upper address bits. It adds what the single-target decode lacks: per-slave wait states through a ready handshake, read-data capture, a decode/timeout error response, and busy/overrun flags. It sits between the CPU AXI-lite interface and the Flipper sub-blocks.

Parameters:
NUM_SLAVES, 4, number of downstream targets (1..16)
ADDR_WIDTH, 16, upstream address width
LOCAL_WIDTH, 12, low address bits forwarded to the slave; selector = addr[ADDR_WIDTH-1:LOCAL_WIDTH]
DATA_WIDTH, 32, register data width
TIMEOUT, 256, maximum cycles to wait for slave ready (>=2)
SLAVE_MASK, {NUM_SLAVES{1'b1}}, bit i=1 means slave i is populated

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_read  in  1  single-cycle read request
cpu_write  in  1  single-cycle write request
cpu_addr  in  ADDR_WIDTH  request address
cpu_wdata  in  DATA_WIDTH  write data
cpu_rdata  out  DATA_WIDTH  read result, held until the next completion
cpu_done  out  1  one-cycle completion pulse
cpu_error  out  1  valid with cpu_done; 1 = decode miss or timeout
cpu_busy  out  1  high whenever the FSM is not IDLE
cpu_overrun  out  1  one-cycle pulse when a request is dropped because the block is busy
s_read  out  NUM_SLAVES  one-hot read strobe
s_write  out  NUM_SLAVES  one-hot write strobe
s_addr  out  LOCAL_WIDTH  latched local address
s_wdata  out  DATA_WIDTH  latched write data
s_rdata  in  NUM_SLAVES*DATA_WIDTH  flattened read data; slave i at [i*DATA_WIDTH +: DATA_WIDTH]
s_ready  in  NUM_SLAVES  slave i has completed the access (held or pulsed)

Behaviour:
- Reset (async): state=IDLE. All outputs are 0: cpu_rdata, cpu_done, cpu_error, cpu_busy, cpu_overrun, s_read, s_write, s_addr, s_wdata. Timeout counter cleared. A reset during any state aborts the access with no cpu_done.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On cpu_read|cpu_write, latch op, selector, local address and wdata.
  - If both strobes are high, the write wins and the read is discarded.
  - If selector >= NUM_SLAVES or SLAVE_MASK[sel]==0, go to RESP with error=1 and rdata=0.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - s_read[sel] or s_write[sel] is high for exactly this cycle; s_addr and s_wdata are valid from ISSUE through RESP.
  - If s_ready[sel] is high this cycle, capture rdata and go to RESP. Otherwise go to WAIT.
- WAIT:
  - Strobes are low. The counter increments each cycle.
  - When s_ready[sel] is seen, capture rdata (reads only) and go to RESP with error=0.
  - If the count reaches TIMEOUT-1 without ready, go to RESP with error=1 and rdata=0.
  - s_ready from non-selected slaves is ignored.
- RESP (1 cycle): cpu_done=1 and cpu_error is valid. cpu_rdata updates on reads only; writes leave it unchanged. Return to IDLE. The counter clears.
- Latency, zero-wait slave: request in cycle 0, strobe in cycle 1, cpu_done in cycle 2. Each slave wait cycle adds 1. Timeout: cpu_done in cycle TIMEOUT+1 after the request.
- Busy handling: cpu_busy = (state != IDLE). A request arriving while busy (including in RESP) is dropped and cpu_overrun pulses in the following cycle. A new request is accepted in the cycle after RESP.
- Counter width is $clog2(TIMEOUT+1) and it never wraps.

Decomposition:
- Package flipper_bus_pkg holds:
  - the FSM state enum (IDLE/ISSUE/WAIT/RESP)
  - the ERR_RDATA constant (all zeros)
  - a localparam helper for selector width = ADDR_WIDTH-LOCAL_WIDTH
- One sub-module, bus_timeout_counter: clear/enable inputs and an expired output, parametrised by TIMEOUT. Everything else stays in cpu_bus_router.

Test Plan:
- Write addr 0x1004, data 0xCAFEF00D, slave 1 ready in ISSUE -> s_write=4'b0010 in cycle 1, s_addr=0x004, s_wdata=0xCAFEF00D; cpu_done cycle 2, error=0.
- Read addr 0x2010, slave 2 raises ready 3 cycles after the strobe with s_rdata slice 0x12345678 -> cpu_rdata=0x12345678, done in cycle 5, error=0.
- Read addr 0x7000 with NUM_SLAVES=4 -> no s_read asserted; done in cycle 1 with error=1 and rdata=0. Repeat with SLAVE_MASK=4'b1101 and addr 0x1000 -> same response.
- Read slave 0 never ready, TIMEOUT=8 -> done in cycle 9, error=1, rdata=0; the next access to slave 0 with ready succeeds normally.
- Second request one cycle after the first, and again during RESP -> both dropped, cpu_overrun pulses twice, the first access completes normally. Simultaneous read+write -> only s_write asserted.
- Assert reset during WAIT -> all outputs 0 immediately, no cpu_done; a fresh read after release completes correctly.

Source files
------------

// File: rtl/flipper_bus_pkg.sv
// Shared types and constants for the Flipper CPU register bus router.
// Holds the router FSM states, the error read-data value and the selector-width helper.
package flipper_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } bus_state_e;

  localparam int MAX_DATA_WIDTH = 256;

  // Read data returned on a decode miss or timeout; sliced to the bus width by users.
  localparam logic [MAX_DATA_WIDTH-1:0] ERR_RDATA = '0;

  localparam int DEF_ADDR_WIDTH  = 16;
  localparam int DEF_LOCAL_WIDTH = 12;

  function automatic int sel_width(input int addr_w, input int local_w);
    return addr_w - local_w;
  endfunction

  localparam int DEF_SEL_WIDTH = sel_width(DEF_ADDR_WIDTH, DEF_LOCAL_WIDTH);

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating wait-state counter for the bus router.
// expired is high once TIMEOUT-1 enabled cycles have elapsed since the last clear.
module bus_timeout_counter #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      // Holding at LIMIT keeps the count from ever wrapping.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/cpu_bus_router.sv
// Routes one CPU register access to one of NUM_SLAVES Flipper sub-blocks by upper address bits,
// with per-slave ready wait states, read-data capture, decode/timeout errors and overrun flagging.
module cpu_bus_router
  import flipper_bus_pkg::*;
#(
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int LOCAL_WIDTH = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 256,
  parameter logic [NUM_SLAVES-1:0] SLAVE_MASK = {NUM_SLAVES{1'b1}}
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cpu_read,
  input  logic                             cpu_write,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic [DATA_WIDTH-1:0]            cpu_wdata,
  output logic [DATA_WIDTH-1:0]            cpu_rdata,
  output logic                             cpu_done,
  output logic                             cpu_error,
  output logic                             cpu_busy,
  output logic                             cpu_overrun,
  output logic [NUM_SLAVES-1:0]            s_read,
  output logic [NUM_SLAVES-1:0]            s_write,
  output logic [LOCAL_WIDTH-1:0]           s_addr,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]            s_ready
);

  localparam int SEL_W = sel_width(ADDR_WIDTH, LOCAL_WIDTH);
  localparam logic [DATA_WIDTH-1:0] ERR_VAL = ERR_RDATA[DATA_WIDTH-1:0];

  bus_state_e state_q, state_d;

  logic                   op_write_q, op_write_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [LOCAL_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   overrun_q, overrun_d;

  logic                   cnt_clear;
  logic                   cnt_en;
  logic                   cnt_expired;

  logic [SEL_W-1:0]       req_sel;
  logic                   req_hit;
  logic                   cpu_req;
  logic [NUM_SLAVES-1:0]  sel_onehot;
  logic                   sel_ready;
  logic [DATA_WIDTH-1:0]  sel_rdata;

  assign req_sel = cpu_addr[ADDR_WIDTH-1:LOCAL_WIDTH];
  assign cpu_req = cpu_read | cpu_write;

  // A selector hits only if it names an existing, populated slave.
  always_comb begin
    req_hit = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if ((SEL_W'(i) == req_sel) && SLAVE_MASK[i]) begin
        req_hit = 1'b1;
      end
    end
  end

  // Only the latched slave's ready and read data are observed.
  always_comb begin
    sel_onehot = '0;
    sel_ready  = 1'b0;
    sel_rdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (SEL_W'(i) == sel_q) begin
        sel_onehot[i] = 1'b1;
        sel_ready     = s_ready[i];
        sel_rdata     = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    overrun_d  = (state_q != ST_IDLE) && cpu_req;
    cnt_clear  = 1'b1;
    cnt_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          // Write has priority when both strobes arrive together.
          op_write_d = cpu_write;
          sel_d      = req_sel;
          addr_d     = cpu_addr[LOCAL_WIDTH-1:0];
          wdata_d    = cpu_wdata;
          err_d      = 1'b0;
          if (req_hit) begin
            state_d = ST_ISSUE;
          end else begin
            err_d = 1'b1;
            if (!cpu_write) begin
              rdata_d = ERR_VAL;
            end
            state_d = ST_RESP;
          end
        end
      end

      ST_ISSUE: begin
        cnt_clear = 1'b0;
        cnt_en    = 1'b1;
        if (sel_ready) begin
          if (!op_write_q) begin
            rdata_d = sel_rdata;
          end
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_clear = 1'b0;
        cnt_en    = 1'b1;
        // Ready on the final counted cycle still completes without error.
        if (sel_ready) begin
          if (!op_write_q) begin
            rdata_d = sel_rdata;
          end
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_expired) begin
          if (!op_write_q) begin
            rdata_d = ERR_VAL;
          end
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_write_q <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      overrun_q  <= overrun_d;
    end
  end

  bus_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .expired (cnt_expired)
  );

  // Strobes are pure decodes of the ISSUE state, so they last exactly one cycle.
  assign s_read      = ((state_q == ST_ISSUE) && !op_write_q) ? sel_onehot : '0;
  assign s_write     = ((state_q == ST_ISSUE) &&  op_write_q) ? sel_onehot : '0;
  assign s_addr      = addr_q;
  assign s_wdata     = wdata_q;
  assign cpu_rdata   = rdata_q;
  assign cpu_done    = (state_q == ST_RESP);
  assign cpu_error   = (state_q == ST_RESP) && err_q;
  assign cpu_busy    = (state_q != ST_IDLE);
  assign cpu_overrun = overrun_q;

endmodule
